// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
// Bundle of the issue, writeback and status signals between the decode stage
// and the register scoreboard.
//
// Handshake: decode presents an instruction with issueValid. The scoreboard
// answers in the same cycle. issueAccept=1 means the instruction issues on
// this rising edge. issueStall=1 means decode must hold the same instruction
// and present it again. A writeback is a single-cycle pulse on wbValid that
// needs no response.
//
// Modports:
//   master - decode/writeback side: drives the issue, writeback and flush
//            inputs; observes stall, accept and status.
//   slave  - scoreboard side: the mirror image of master.
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_BITS  = 3,
    parameter int PERF_BITS = 16
);
    logic                 issueValid;
    logic                 issueRd1En;
    logic [SEL_BITS-1:0]  issueRd1Sel;
    logic                 issueRd2En;
    logic [SEL_BITS-1:0]  issueRd2Sel;
    logic                 issueWrEn;
    logic [SEL_BITS-1:0]  issueWrReg;
    logic                 wbValid;
    logic [SEL_BITS-1:0]  wbReg;
    logic                 flush;
    logic                 issueStall;
    logic                 issueAccept;
    logic [NUM_REGS-1:0]  pendingMask;
    logic [PERF_BITS-1:0] stallCycles;
    logic                 err;

    modport master (
        output issueValid, issueRd1En, issueRd1Sel, issueRd2En, issueRd2Sel,
        output issueWrEn, issueWrReg, wbValid, wbReg, flush,
        input  issueStall, issueAccept, pendingMask, stallCycles, err
    );

    modport slave (
        input  issueValid, issueRd1En, issueRd1Sel, issueRd2En, issueRd2Sel,
        input  issueWrEn, issueWrReg, wbValid, wbReg, flush,
        output issueStall, issueAccept, pendingMask, stallCycles, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Issue-side hazard controller for an 8-entry register file. It keeps one
// saturating-free outstanding-write counter per architectural register. It
// stalls issue when a source register has a write in flight (RAW). It also
// stalls when the destination counter is already at its maximum. Pending
// state clears as writebacks retire.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - reg_scoreboard_if.slave:
//            in : issueValid, issueRd1En/Sel, issueRd2En/Sel, issueWrEn,
//                 issueWrReg, wbValid, wbReg, flush
//            out: issueStall, issueAccept (combinational),
//                 pendingMask, stallCycles, err (registered)
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_BITS  = 3,
    parameter int CNT_BITS  = 2,
    parameter int PERF_BITS = 16
) (
    input logic            clk,
    input logic            rst,
    reg_scoreboard_if.slave bus
);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0]  r_cnt [NUM_REGS];
    logic [CNT_BITS-1:0]  w_cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0]  r_pending;
    logic [PERF_BITS-1:0] r_stall_cycles;
    logic                 r_err;

    logic                 w_raw;
    logic                 w_sat;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_illegal_wb;
    logic [NUM_REGS-1:0]  w_inc;
    logic [NUM_REGS-1:0]  w_dec;

    // Hazards look only at registered counts. A writeback in the same cycle
    // does not unblock a reader until the following cycle.
    always_comb begin
        w_raw = (bus.issueRd1En && (r_cnt[bus.issueRd1Sel] != '0)) ||
                (bus.issueRd2En && (r_cnt[bus.issueRd2Sel] != '0));
        w_sat = bus.issueWrEn && (r_cnt[bus.issueWrReg] == CNT_MAX);
        w_stall  = bus.issueValid && (w_raw || w_sat) && !bus.flush;
        w_accept = bus.issueValid && !w_stall && !bus.flush;
        // A retire against an idle counter is a protocol error, except while
        // flushing, when writebacks are discarded.
        w_illegal_wb = bus.wbValid && !bus.flush &&
                       (r_cnt[bus.wbReg] == '0);
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = w_accept && bus.issueWrEn &&
                       (bus.issueWrReg == SEL_BITS'(i));
            w_dec[i] = bus.wbValid && (bus.wbReg == SEL_BITS'(i)) &&
                       (r_cnt[i] != '0);
        end
    end

    // Increment cannot wrap because a full counter blocks the accept.
    // Decrement cannot wrap because it is gated on a non-zero count.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (bus.flush) begin
                w_cnt_next[i] = '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                w_cnt_next[i] = r_cnt[i] + CNT_BITS'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cnt_next[i] = r_cnt[i] - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending      <= '0;
            r_stall_cycles <= '0;
            r_err          <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i]     <= w_cnt_next[i];
                r_pending[i] <= (w_cnt_next[i] != '0);
            end
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_BITS'(1);
            end
            if (w_illegal_wb) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.issueStall  = w_stall;
    assign bus.issueAccept = w_accept;
    assign bus.pendingMask = r_pending;
    assign bus.stallCycles = r_stall_cycles;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int NUM_REGS  = 8;
  localparam int SEL_BITS  = 3;
  localparam int CNT_MAX   = 3;
  localparam int PERF_MAX  = 65535;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .SEL_BITS(SEL_BITS), .PERF_BITS(16)) bus_if ();

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .SEL_BITS(SEL_BITS), .CNT_BITS(2), .PERF_BITS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt [NUM_REGS];
  bit m_err;
  int m_stalls;

  function automatic void model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    m_err    = 1'b0;
    m_stalls = 0;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) if (m_cnt[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit model_stall();
    bit raw;
    bit sat;
    raw = (bus_if.issueRd1En && m_cnt[bus_if.issueRd1Sel] > 0) ||
          (bus_if.issueRd2En && m_cnt[bus_if.issueRd2Sel] > 0);
    sat = bus_if.issueWrEn && (m_cnt[bus_if.issueWrReg] == CNT_MAX);
    return bus_if.issueValid && (raw || sat) && !bus_if.flush;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  function automatic void model_step();
    bit stall;
    bit accept;
    int old_wb;
    stall  = model_stall();
    accept = bus_if.issueValid && !stall && !bus_if.flush;
    if (stall && m_stalls < PERF_MAX) m_stalls++;
    if (bus_if.flush) begin
      for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    end else begin
      old_wb = m_cnt[bus_if.wbReg];
      if (bus_if.wbValid && old_wb == 0) m_err = 1'b1;
      if (accept && bus_if.issueWrEn) m_cnt[bus_if.issueWrReg]++;
      if (bus_if.wbValid && old_wb > 0) m_cnt[bus_if.wbReg]--;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit st;
    st = model_stall();
    chk({tag, ".stall"},  32'(bus_if.issueStall),  32'(st));
    chk({tag, ".accept"}, 32'(bus_if.issueAccept),
        32'(bus_if.issueValid && !st && !bus_if.flush));
    chk({tag, ".mask"},   32'(bus_if.pendingMask), 32'(model_mask()));
    chk({tag, ".stalls"}, 32'(bus_if.stallCycles), 32'(m_stalls));
    chk({tag, ".err"},    32'(bus_if.err),         32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                       input bit we, input int wr, input bit wbv, input int wb, input bit fl);
    bus_if.issueValid  = v;
    bus_if.issueRd1En  = r1e;
    bus_if.issueRd1Sel = SEL_BITS'(r1);
    bus_if.issueRd2En  = r2e;
    bus_if.issueRd2Sel = SEL_BITS'(r2);
    bus_if.issueWrEn   = we;
    bus_if.issueWrReg  = SEL_BITS'(wr);
    bus_if.wbValid     = wbv;
    bus_if.wbReg       = SEL_BITS'(wb);
    bus_if.flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a rising edge; inputs are already applied.
  task automatic do_cycle(input string tag, input bit chk_en);
    @(negedge clk);
    if (chk_en) check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    model_clear();
    #1;
    chk("rst.mask",   32'(bus_if.pendingMask), 32'h0);
    chk("rst.stalls", 32'(bus_if.stallCycles), 32'h0);
    chk("rst.err",    32'(bus_if.err),         32'h0);
    chk("rst.stall",  32'(bus_if.issueStall),  32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycle();
    int pend_q[$];
    int wb;
    bit wbv;
    for (int i = 0; i < NUM_REGS; i++) if (m_cnt[i] > 0) pend_q.push_back(i);
    wbv = ($urandom_range(0, 2) != 0);
    if (pend_q.size() > 0 && $urandom_range(0, 9) != 0)
      wb = pend_q[$urandom_range(0, pend_q.size() - 1)];
    else
      wb = $urandom_range(0, NUM_REGS - 1);
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7),
          wbv, wb, ($urandom_range(0, 19) == 0));
    do_cycle("rand", 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write r3, then read r3 -> stall.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    do_cycle("wr_r3", 1'b1);
    chk("wr_r3.mask_const", 32'(bus_if.pendingMask), 32'h08);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("rd_r3", 1'b1);
    chk("rd_r3.stalls_const", 32'(bus_if.stallCycles), 32'd1);

    // Writeback r3 while reading it: still stalled, accepted next cycle.
    drive(1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
    do_cycle("rd_r3_wb", 1'b1);
    chk("wb_r3.mask_const", 32'(bus_if.pendingMask), 32'h00);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("rd_r3_ok", 1'b1);

    // Source equal to destination with no prior pending write.
    drive(1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    do_cycle("addi_r1", 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    do_cycle("wb_r1", 1'b1);

    // Saturate r5, fourth write stalls, then inc+dec in one cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      do_cycle("wr_r5", 1'b1);
    end
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    do_cycle("wr_r5_sat", 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    do_cycle("wb_r5", 1'b1);
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
    do_cycle("wr_wb_r5", 1'b1);
    chk("r5.model_cnt_held", 32'(bus_if.pendingMask), 32'h20);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    do_cycle("drain_r5a", 1'b1);
    do_cycle("drain_r5b", 1'b1);
    chk("r5.drained", 32'(bus_if.pendingMask), 32'h00);

    // Flush with r2 and r6 pending and a same-cycle writeback.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    do_cycle("wr_r2", 1'b1);
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    do_cycle("wr_r6", 1'b1);
    drive(1, 0, 0, 0, 0, 1, 7, 1, 2, 1);
    do_cycle("flush", 1'b1);
    chk("flush.mask_const", 32'(bus_if.pendingMask), 32'h00);
    chk("flush.err_const",  32'(bus_if.err),         32'h0);

    // Illegal retire, sticky through flush, cleared by reset.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    do_cycle("bad_wb", 1'b1);
    chk("bad_wb.err_const", 32'(bus_if.err), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_cycle("flush_err", 1'b1);
    chk("flush_err.err_const", 32'(bus_if.err), 32'h1);
    do_reset();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) random_cycle();
    do_reset();

    // Stall-counter saturation, then asynchronous reset mid-stall.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    do_cycle("sat_wr_r1", 1'b1);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 65536 + 5; k++) do_cycle("perf", (k < 3) || (k > 65530));
    chk("perf.sat_const", 32'(bus_if.stallCycles), 32'hFFFF);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    chk("arst.mask",   32'(bus_if.pendingMask), 32'h0);
    chk("arst.stalls", 32'(bus_if.stallCycles), 32'h0);
    chk("arst.err",    32'(bus_if.err),         32'h0);
    chk("arst.stall",  32'(bus_if.issueStall),  32'h0);
    chk("arst.accept", 32'(bus_if.issueAccept), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    idle();
    do_cycle("post_rst", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
